// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the helper that sizes the bit counter.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // clog2(w) with a floor of one bit, so W=1 still gets a real counter.
    function automatic int unsigned cnt_width(input int unsigned w);
        int unsigned r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'd1 << i) < w) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = a - b - bi, with borrow-out.
module serial_subtractor_full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    always_comb begin
        d  = a ^ b ^ bi;
        bo = (~a & b) | (~(a ^ b) & bi);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first W-bit subtractor with start/busy/done handshake.
// One full-subtractor cell is reused W times with a registered borrow.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bi,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         bo
);

    localparam int unsigned CW = cnt_width(W);
    localparam logic [CW-1:0] LastBit = CW'(W - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  res_q, res_d;
    logic [W-1:0]  d_q, d_d;
    logic          borrow_q, borrow_d;
    logic          bo_q, bo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cell_d, cell_bo;
    logic [W-1:0]  diff_msb;
    logic          accept;

    serial_subtractor_full_subtractor u_cell (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .bi (borrow_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    assign accept = start && (state_q != ST_RUN);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        bo_d     = bo_q;
        cnt_d    = cnt_q;
        diff_msb = '0;
        diff_msb[W-1] = cell_d;

        case (state_q)
            ST_RUN: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                borrow_d = cell_bo;
                res_d    = (res_q >> 1) | diff_msb;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    // Publish on the last bit so d/bo are stable for all of DONE.
                    d_d     = res_d;
                    bo_d    = cell_bo;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_IDLE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            state_d  = ST_RUN;
            a_d      = a;
            b_d      = b;
            borrow_d = bi;
            res_d    = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            bo_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
            bo_q     <= bo_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign d    = d_q;
    assign bo   = bo_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first W-bit subtractor computing d = a - b - bi with borrow-out.
- Inverse-direction counterpart of the combinational ripple adder: one full-subtractor cell is reused W times with a registered borrow.
- Used where area matters more than latency. Controlled by a start/busy/done handshake.

Parameters:
- W, 4, operand and result width in bits (W >= 1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request to begin an operation; sampled only when not busy.
- a  in  W  minuend; captured on accepted start.
- b  in  W  subtrahend; captured on accepted start.
- bi  in  1  borrow-in; captured on accepted start.
- busy  out  1  high while an operation is in progress (RUN state).
- done  out  1  one-cycle pulse when d/bo become valid.
- d  out  W  difference (a - b - bi) mod 2^W.
- bo  out  1  borrow-out; 1 when a < b + bi as unsigned values.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; busy=0, done=0, d=0, bo=0; internal shift registers, borrow and counter cleared. Reset has priority over everything, including mid-operation. The in-flight result is discarded and no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a into shift register A, b into B and bi into borrow register; counter=0; next state RUN.
  - start=0: remain in IDLE.
- RUN, one bit per cycle:
  - diff = A[0] ^ B[0] ^ borrow.
  - borrow_next = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & borrow).
  - Shift diff into result register from the MSB side, shift A and B right by 1, counter+1.
  - After the W-th bit (counter == W-1), next state DONE.
  - busy=1 throughout RUN. start is ignored while in RUN and the operands do not change.
- DONE, lasts exactly one cycle:
  - done=1; d = result register, bo = final borrow.
  - busy=0.
  - If start=1 in DONE, new operands are accepted exactly as from IDLE and the next state is RUN (back-to-back operation). Otherwise the next state is IDLE.
- Latency: start accepted at edge 0; done high in cycle W+1 (edges counted from acceptance). Throughput is one result per W+1 cycles back-to-back.
- d and bo hold their last value until the next DONE or reset. They are not cleared on start.
- Arithmetic is unsigned modulo 2^W. Check: d + b + bi == a + bo*2^W.
- Boundary cases:
  - W=1 gives a 1-cycle RUN.
  - a=b with bi=0 gives d=0, bo=0.
  - 0 - 0 - 1 gives all-ones with bo=1.
  - Counter width is clog2(W), minimum 1 bit. No wrap-around is reachable beyond W-1.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_RUN, ST_DONE) and a clog2 helper function for the counter width.
- Sub-module full_subtractor: combinational 1-bit cell with inputs a, b, bi and outputs d, bo. It is the mirror of the adder's full-adder cell and is instantiated once in the datapath.

Test Plan:
- W=4, a=0101, b=0011, bi=0, start pulse -> busy for 4 cycles, done pulse in cycle 5, d=0010, bo=0.
- W=4, a=0011, b=0101, bi=0 -> d=1110, bo=1. Then a=0000, b=0000, bi=1 -> d=1111, bo=1.
- Exhaustive: all 256 (a,b) pairs at bi=0 and bi=1, with start held high so operations run back-to-back -> every done carries d=(a-b-bi) mod 16 and bo=(a<b+bi), and consecutive dones are spaced by exactly 5 cycles.
- start re-asserted with different operands during RUN -> ignored; result matches the original operands; exactly one done pulse.
- rst=1 in the second RUN cycle -> next cycle busy=0, done=0, d=0, bo=0, no done pulse. A following start with a=1001, b=0001 gives d=1000, bo=0.
- Parameter sweep W=1 and W=8: W=1 with a=0, b=1 -> d=1, bo=1, done in cycle 2. W=8 with a=0x80, b=0x01 -> d=0x7F, bo=0, done in cycle 9.
